// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - byte FIFO feeding a UART frame serializer paced by baud_tick
module uart_tx_serializer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEVEL_W    = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_baud_tick,
   input  logic               i_tx_valid,
   input  logic [7:0]         i_tx_data,
   output logic               o_tx_ready,
   input  logic               i_cfg_parity_en,
   input  logic               i_cfg_parity_odd,
   input  logic               i_cfg_two_stop,
   output logic               o_txd,
   output logic               o_busy,
   output logic [LEVEL_W-1:0] o_fifo_level
);

   localparam int                 PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [LEVEL_W-1:0] FULL  = LEVEL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [LEVEL_W-1:0] r_level;

   state_t             r_state, w_state_nxt;
   logic [7:0]         r_data, w_data_nxt;
   logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
   logic               r_stop_cnt, w_stop_cnt_nxt;
   logic               r_par_en, w_par_en_nxt;
   logic               r_par_odd, w_par_odd_nxt;
   logic               r_two_stop, w_two_stop_nxt;
   logic               r_txd, w_txd_nxt;

   logic               w_push;
   logic               w_pop;
   logic               w_load;
   logic               w_has_data;
   logic [2:0]         w_bit_idx;
   logic               w_parity;

   // Ready looks only at the stored level, so a full FIFO refuses a push even when popping.
   assign o_tx_ready   = (r_level < FULL);
   assign w_push       = i_tx_valid && o_tx_ready;
   assign w_has_data   = (r_level != '0);
   assign w_pop        = w_load;
   assign w_bit_idx    = r_bit_cnt + 3'd1;
   assign w_parity     = r_par_odd ? ~^r_data : ^r_data;

   assign o_txd        = r_txd;
   assign o_busy       = (r_state != IDLE);
   assign o_fifo_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_tx_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LEVEL_W'(1);
            2'b01:   r_level <= r_level - LEVEL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_data     <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
         r_txd      <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_data     <= w_data_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_par_en   <= w_par_en_nxt;
         r_par_odd  <= w_par_odd_nxt;
         r_two_stop <= w_two_stop_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_data_nxt     = r_data;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_par_en_nxt   = r_par_en;
      w_par_odd_nxt  = r_par_odd;
      w_two_stop_nxt = r_two_stop;
      w_txd_nxt      = r_txd;
      w_load         = 1'b0;
      if (i_baud_tick) begin
         case (r_state)
            IDLE: begin
               w_load = w_has_data;
            end
            START: begin
               w_txd_nxt     = r_data[0];
               w_bit_cnt_nxt = '0;
               w_state_nxt   = DATA;
            end
            DATA: begin
               if (r_bit_cnt != 3'd7) begin
                  w_txd_nxt     = r_data[w_bit_idx];
                  w_bit_cnt_nxt = w_bit_idx;
               end else if (r_par_en) begin
                  w_txd_nxt   = w_parity;
                  w_state_nxt = PARITY;
               end else begin
                  w_txd_nxt      = 1'b1;
                  w_stop_cnt_nxt = 1'b0;
                  w_state_nxt    = STOP;
               end
            end
            PARITY: begin
               w_txd_nxt      = 1'b1;
               w_stop_cnt_nxt = 1'b0;
               w_state_nxt    = STOP;
            end
            STOP: begin
               if (r_two_stop && !r_stop_cnt) begin
                  w_stop_cnt_nxt = 1'b1;
                  w_txd_nxt      = 1'b1;
               end else if (w_has_data) begin
                  w_load = 1'b1;
               end else begin
                  w_txd_nxt   = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_txd_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end
         endcase
      end
      // Frame config is captured with the byte so mid-frame changes only affect later frames.
      if (w_load) begin
         w_data_nxt     = r_mem[r_rd_ptr];
         w_par_en_nxt   = i_cfg_parity_en;
         w_par_odd_nxt  = i_cfg_parity_odd;
         w_two_stop_nxt = i_cfg_two_stop;
         w_txd_nxt      = 1'b0;
         w_state_nxt    = START;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_push && (r_level == FULL)));
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(w_pop && (r_level == '0)));
   a_level_bound: assert property (@(posedge clk) disable iff (!reset_n)
      r_level <= FULL);

endmodule
